// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute
// and drives every datapath enable, mux select and ALU op from registered state.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [4:0] alu_ctrl,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    // state    | meaning
    // BOOT     | post-reset idle cycle
    // FETCH    | IR <= mem[PC], PC <= PC+4
    // DECODE   | alu_out <= old_pc + imm (branch/jump target)
    // MEMADR   | alu_out <= rs1 + imm
    // MEMREAD  | read data memory at alu_out
    // MEMWB    | rd <= mem_data
    // MEMWRITE | mem[alu_out] <= rs2
    // EXECR    | R-type ALU op on rs1, rs2
    // EXECI    | I-type ALU op on rs1, imm
    // ALUWB    | rd <= alu_out
    // JAL      | PC <= target, alu_out <= old_pc + 4
    // BEQ      | compare rs1 - rs2, PC <= target when zero
    // ILLEGAL  | halted on unsupported opcode until reset
    typedef enum logic [3:0] {
        S_BOOT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_JAL      = 4'd10,
        S_BEQ      = 4'd11,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;
    localparam logic [4:0] ALU_AND = 5'd2;
    localparam logic [4:0] ALU_OR  = 5'd3;
    localparam logic [4:0] ALU_SLT = 5'd4;

    state_t     state_q;
    state_t     state_next;
    logic       pc_write_q;
    logic [4:0] alu_funct;

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_BOOT:     state_next = S_FETCH;
            S_FETCH:    state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_JAL:       state_next = S_JAL;
                    OP_BEQ:       state_next = S_BEQ;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: state_next = S_ALUWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_next = S_FETCH;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            default:    state_next = S_BOOT;
        endcase
    end

    // funct7b5 selects SUB only for register-register ops; addi ignores it
    always_comb begin
        case (funct3)
            3'b000:  alu_funct = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_funct = ALU_SLT;
            3'b110:  alu_funct = ALU_OR;
            3'b111:  alu_funct = ALU_AND;
            default: alu_funct = ALU_ADD;
        endcase
    end

    // Outputs are registered from the state being entered, so they line up with state_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_write_q <= 1'b0;
            adr_src    <= 1'b0;
            mem_write  <= 1'b0;
            ir_write   <= 1'b0;
            reg_write  <= 1'b0;
            result_src <= 2'b00;
            alu_src_a  <= 2'b00;
            alu_src_b  <= 2'b00;
            alu_ctrl   <= ALU_ADD;
            instr_done <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            state_q    <= state_next;
            pc_write_q <= 1'b0;
            adr_src    <= 1'b0;
            mem_write  <= 1'b0;
            ir_write   <= 1'b0;
            reg_write  <= 1'b0;
            result_src <= 2'b00;
            alu_src_a  <= 2'b00;
            alu_src_b  <= 2'b00;
            alu_ctrl   <= ALU_ADD;
            instr_done <= 1'b0;
            illegal    <= 1'b0;
            case (state_next)
                S_FETCH: begin
                    ir_write   <= 1'b1;
                    alu_src_b  <= 2'b10;
                    result_src <= 2'b10;
                    pc_write_q <= 1'b1;
                end
                S_DECODE: begin
                    alu_src_a <= 2'b01;
                    alu_src_b <= 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a <= 2'b10;
                    alu_src_b <= 2'b01;
                end
                S_MEMREAD: adr_src <= 1'b1;
                S_MEMWB: begin
                    result_src <= 2'b01;
                    reg_write  <= 1'b1;
                    instr_done <= 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src    <= 1'b1;
                    mem_write  <= 1'b1;
                    instr_done <= 1'b1;
                end
                S_EXECR: begin
                    alu_src_a <= 2'b10;
                    alu_ctrl  <= alu_funct;
                end
                S_EXECI: begin
                    alu_src_a <= 2'b10;
                    alu_src_b <= 2'b01;
                    alu_ctrl  <= alu_funct;
                end
                S_ALUWB: begin
                    reg_write  <= 1'b1;
                    instr_done <= 1'b1;
                end
                S_JAL: begin
                    alu_src_a  <= 2'b01;
                    alu_src_b  <= 2'b10;
                    pc_write_q <= 1'b1;
                end
                S_BEQ: begin
                    alu_src_a  <= 2'b10;
                    alu_ctrl   <= ALU_SUB;
                    instr_done <= 1'b1;
                end
                S_ILLEGAL: illegal <= 1'b1;
                default: ;
            endcase
        end
    end

    // Branch decision uses the live ALU zero flag in the BEQ cycle
    assign pc_write = pc_write_q | ((state_q == S_BEQ) & zero);
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instruction
// streams compared cycle by cycle against a per-instruction state/output model.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [4:0] alu_ctrl;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write),
        .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] observed();
        return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_ctrl, instr_done, illegal};
    endfunction

    // Expected outputs for the given state number of an instruction, from the
    // state descriptions: {pc,adr,mw,ir,rw,rs,a,b,alu,done,illegal}
    function automatic logic [17:0] exp_out(int s, logic [2:0] f3, logic f7, logic z);
        logic       pc, adr, mw, ir, rw, dn, il;
        logic [1:0] rs, a, b;
        logic [4:0] alu, fop;
        pc = 0; adr = 0; mw = 0; ir = 0; rw = 0; dn = 0; il = 0;
        rs = 0; a = 0; b = 0; alu = 0;
        if (f3 == 3'd2)      fop = 5'd4;
        else if (f3 == 3'd6) fop = 5'd3;
        else if (f3 == 3'd7) fop = 5'd2;
        else if (f3 == 3'd0 && s == 7 && f7) fop = 5'd1;
        else                 fop = 5'd0;
        case (s)
            1:  begin pc = 1; ir = 1; rs = 2'b10; b = 2'b10; end
            2:  begin a = 2'b01; b = 2'b01; end
            3:  begin a = 2'b10; b = 2'b01; end
            4:  adr = 1;
            5:  begin rs = 2'b01; rw = 1; dn = 1; end
            6:  begin adr = 1; mw = 1; dn = 1; end
            7:  begin a = 2'b10; alu = fop; end
            8:  begin a = 2'b10; b = 2'b01; alu = fop; end
            9:  begin rw = 1; dn = 1; end
            10: begin a = 2'b01; b = 2'b10; pc = 1; end
            11: begin a = 2'b10; alu = 5'd1; pc = z; dn = 1; end
            15: il = 1;
            default: ;
        endcase
        return {pc, adr, mw, ir, rw, rs, a, b, alu, dn, il};
    endfunction

    // Entered at a negedge with the DUT in FETCH. zmode<0 randomizes zero each cycle.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int zmode, input string name);
        int seq[$];
        int dones;
        int want_dones;
        logic [17:0] want;
        opcode = op; funct3 = f3; funct7b5 = f7;
        seq = {1, 2};
        want_dones = 1;
        case (op)
            7'b0000011: seq = {seq, 3, 4, 5};
            7'b0100011: seq = {seq, 3, 6};
            7'b0110011: seq = {seq, 7, 9};
            7'b0010011: seq = {seq, 8, 9};
            7'b1101111: seq = {seq, 10, 9};
            7'b1100011: seq = {seq, 11};
            default: begin
                repeat (10) seq.push_back(15);
                want_dones = 0;
            end
        endcase
        dones = 0;
        foreach (seq[i]) begin
            zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            checks++;
            if (state !== 4'(seq[i])) begin
                errors++;
                $display("FAIL %s state step %0d: got %0d want %0d", name, i, state, seq[i]);
            end
            want = exp_out(seq[i], f3, f7, zero);
            checks++;
            if (observed() !== want) begin
                errors++;
                $display("FAIL %s outputs step %0d (state %0d): got %05h want %05h",
                         name, i, seq[i], observed(), want);
            end
            if (instr_done === 1'b1) dones++;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (dones !== want_dones) begin
            errors++;
            $display("FAIL %s instr_done count: got %0d want %0d", name, dones, want_dones);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            zero = 1'b1;
            #1;
            checks++;
            if (state !== 4'd0 || observed() !== 18'd0) begin
                errors++;
                $display("FAIL reset_hold: got state %0d outs %05h want 0 00000", state, observed());
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: got state %0d want 0", state);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_add_sub();
        logic [31:0] w;
        w = 32'h002081B3;
        run_instr(w[6:0], w[14:12], w[30], -1, "add");
        w = 32'h402081B3;
        run_instr(w[6:0], w[14:12], w[30], -1, "sub");
        run_instr(7'b0010011, 3'b000, 1'b1, -1, "addi_f7");
    endtask

    task automatic test_each_type();
        run_instr(7'b0000011, 3'b010, 1'b0, -1, "lw");
        run_instr(7'b0100011, 3'b010, 1'b1, -1, "sw");
        run_instr(7'b1100011, 3'b000, 1'b0, 1, "beq_taken");
        run_instr(7'b1100011, 3'b000, 1'b0, 0, "beq_not_taken");
        run_instr(7'b1101111, 3'b000, 1'b0, -1, "jal");
        run_instr(7'b0110011, 3'b111, 1'b0, -1, "and");
        run_instr(7'b0110011, 3'b110, 1'b1, -1, "or");
        run_instr(7'b0010011, 3'b010, 1'b0, -1, "slti");
        run_instr(7'b0010011, 3'b100, 1'b0, -1, "xori_as_add");
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [6];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        for (int n = 0; n < 80; n++) begin
            run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), -1, "random");
        end
    endtask

    task automatic test_illegal();
        run_instr(7'h7F, 3'($urandom_range(0, 7)), 1'b0, -1, "illegal");
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || observed() !== 18'd0) begin
            errors++;
            $display("FAIL illegal_reset: got state %0d outs %05h want 0 00000", state, observed());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run_instr(7'b1100011, 3'b000, 1'b0, 1, "beq_after_illegal");
    endtask

    task automatic test_reset_mid_exec();
        opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        zero = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        checks++;
        if (state !== 4'd7 || alu_ctrl !== 5'd1) begin
            errors++;
            $display("FAIL mid_exec_entry: got state %0d alu %0d want 7 1", state, alu_ctrl);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || observed() !== 18'd0) begin
            errors++;
            $display("FAIL mid_exec_reset: got state %0d outs %05h want 0 00000", state, observed());
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL mid_exec_boot: got state %0d want 0", state);
        end
        @(posedge clk);
        @(negedge clk);
        run_instr(7'b0110011, 3'b000, 1'b0, -1, "add_after_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        test_reset();
        test_add_sub();
        test_each_type();
        test_back_to_back();
        test_illegal();
        test_reset_mid_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
